// File: rtl/rect_flip_sequencer.sv
// Walks a rows x cols rectangle of words through a wowi_adapter, reading each
// word, flipping it (bit or byte order) and writing it back in place.
module rect_flip_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int WORD_BYTES = 2,
  parameter int FLIP_MODE  = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [7:0]                       rect_base,
  input  logic [3:0]                       rect_cols,
  input  logic [3:0]                       rect_rows,
  input  logic [7:0]                       row_stride,
  output logic                             st_read,
  output logic                             st_write,
  output logic [7:0]                       base_addr,
  output logic [DATA_WIDTH*WORD_BYTES-1:0] write_data,
  input  logic [DATA_WIDTH*WORD_BYTES-1:0] read_data,
  input  logic                             flip_ready,
  input  logic                             wrt_done,
  output logic                             busy,
  output logic                             done,
  output logic [7:0]                       word_count
);

  localparam int W = DATA_WIDTH * WORD_BYTES;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_GAP, S_WR, S_WWAIT, S_NEXT, S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     cols_q, cols_d, rows_q, rows_d;
  logic [3:0]     col_q, col_d, row_q, row_d;
  logic [7:0]     stride_q, stride_d;
  logic [7:0]     row_addr_q, row_addr_d;
  logic [7:0]     base_addr_q, base_addr_d;
  logic [W-1:0]   write_data_q, write_data_d;
  logic [7:0]     word_count_q, word_count_d;
  logic           st_read_q, st_read_d, st_write_q, st_write_d;
  logic           busy_q, busy_d, done_q, done_d;
  logic           last_word;

  function automatic logic [W-1:0] flip_word(input logic [W-1:0] din);
    logic [W-1:0] r;
    r = '0;
    if (FLIP_MODE == 0) begin
      for (int i = 0; i < W; i++) r[i] = din[W-1-i];
    end else begin
      for (int k = 0; k < WORD_BYTES; k++)
        r[k*DATA_WIDTH +: DATA_WIDTH] = din[(WORD_BYTES-1-k)*DATA_WIDTH +: DATA_WIDTH];
    end
    return r;
  endfunction

  assign last_word = (col_q == cols_q - 4'd1) && (row_q == rows_q - 4'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cols_q       <= '0;
      rows_q       <= '0;
      col_q        <= '0;
      row_q        <= '0;
      stride_q     <= '0;
      row_addr_q   <= '0;
      base_addr_q  <= '0;
      write_data_q <= '0;
      word_count_q <= '0;
      st_read_q    <= 1'b0;
      st_write_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cols_q       <= cols_d;
      rows_q       <= rows_d;
      col_q        <= col_d;
      row_q        <= row_d;
      stride_q     <= stride_d;
      row_addr_q   <= row_addr_d;
      base_addr_q  <= base_addr_d;
      write_data_q <= write_data_d;
      word_count_q <= word_count_d;
      st_read_q    <= st_read_d;
      st_write_q   <= st_write_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // The final word skips S_NEXT so done lands two cycles after its wrt_done;
  // a start coinciding with the done pulse is refused via done_q.
  always_comb begin
    state_d      = state_q;
    cols_d       = cols_q;
    rows_d       = rows_q;
    col_d        = col_q;
    row_d        = row_q;
    stride_d     = stride_q;
    row_addr_d   = row_addr_q;
    base_addr_d  = base_addr_q;
    write_data_d = write_data_q;
    word_count_d = word_count_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !done_q) begin
          cols_d       = rect_cols;
          rows_d       = rect_rows;
          stride_d     = row_stride;
          col_d        = '0;
          row_d        = '0;
          word_count_d = '0;
          busy_d       = 1'b1;
          if (rect_cols == 4'd0 || rect_rows == 4'd0) begin
            state_d = S_DONE;
          end else begin
            base_addr_d = rect_base;
            row_addr_d  = rect_base;
            state_d     = S_RD;
          end
        end
      end
      S_RD: begin
        if (flip_ready) begin
          write_data_d = flip_word(read_data);
          state_d      = S_GAP;
        end
      end
      S_GAP:   state_d = S_WR;
      S_WR:    state_d = S_WWAIT;
      S_WWAIT: begin
        if (wrt_done) begin
          word_count_d = word_count_q + 8'd1;
          state_d      = last_word ? S_DONE : S_NEXT;
        end
      end
      S_NEXT: begin
        if (col_q == cols_q - 4'd1) begin
          row_addr_d  = row_addr_q + stride_q;
          base_addr_d = row_addr_q + stride_q;
          col_d       = '0;
          row_d       = row_q + 4'd1;
        end else begin
          base_addr_d = base_addr_q + 8'(WORD_BYTES);
          col_d       = col_q + 4'd1;
        end
        state_d = S_RD;
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    st_read_d  = (state_d == S_RD);
    st_write_d = (state_d == S_WR);
  end

  assign st_read    = st_read_q;
  assign st_write   = st_write_q;
  assign base_addr  = base_addr_q;
  assign write_data = write_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_rect_flip_sequencer.sv
// Self-checking bench: two sequencers (bit-reverse and byte-swap) share one
// behavioural adapter/BRAM; results are compared with a sequential flip model.
module tb_rect_flip_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        reset, start;
  logic [7:0]  rect_base, row_stride;
  logic [3:0]  rect_cols, rect_rows;
  logic [15:0] read_data;
  logic        flip_ready, wrt_done;

  logic        st_read0, st_write0, busy0, done0;
  logic [7:0]  base_addr0, word_count0;
  logic [15:0] write_data0;
  logic        st_read1, st_write1, busy1, done1;
  logic [7:0]  base_addr1, word_count1;
  logic [15:0] write_data1;

  rect_flip_sequencer #(.DATA_WIDTH(8), .WORD_BYTES(2), .FLIP_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .rect_base(rect_base),
    .rect_cols(rect_cols), .rect_rows(rect_rows), .row_stride(row_stride),
    .st_read(st_read0), .st_write(st_write0), .base_addr(base_addr0),
    .write_data(write_data0), .read_data(read_data), .flip_ready(flip_ready),
    .wrt_done(wrt_done), .busy(busy0), .done(done0), .word_count(word_count0));

  rect_flip_sequencer #(.DATA_WIDTH(8), .WORD_BYTES(2), .FLIP_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .rect_base(rect_base),
    .rect_cols(rect_cols), .rect_rows(rect_rows), .row_stride(row_stride),
    .st_read(st_read1), .st_write(st_write1), .base_addr(base_addr1),
    .write_data(write_data1), .read_data(read_data), .flip_ready(flip_ready),
    .wrt_done(wrt_done), .busy(busy1), .done(done1), .word_count(word_count1));

  logic [7:0]  mem [256];
  logic [7:0]  seed_mem [256];
  logic [7:0]  model_mem [256];
  logic [7:0]  log_addr0 [$];
  logic [7:0]  log_addr1 [$];
  logic [15:0] log_data0 [$];
  logic [15:0] log_data1 [$];
  logic        log_wr1 [$];
  logic [7:0]  exp_addr [$];
  logic [15:0] exp_d0 [$];
  logic [15:0] exp_d1 [$];
  int load_req = 0, load_ack = 0;
  int done_count0 = 0, done_count1 = 0, req_count = 0;
  int last_wrt_cyc = 0;
  bit hold_wr = 1'b0, rd_busy = 1'b0, wr_busy = 1'b0;
  int rd_cnt = 0, wr_cnt = 0;
  logic [7:0] rd_addr = '0;
  int checks = 0, errors = 0;
  int pass_base = 0;

  // Adapter/BRAM model: random read/write latency, stray pulses while idle.
  initial begin
    logic [7:0] a1;
    flip_ready = 1'b0;
    wrt_done   = 1'b0;
    read_data  = '0;
    forever begin
      @(negedge clk);
      flip_ready = 1'b0;
      wrt_done   = 1'b0;
      if (load_req != load_ack) begin
        for (int i = 0; i < 256; i++) mem[i] = seed_mem[i];
        load_ack = load_req;
      end
      if (reset) begin
        rd_busy = 1'b0;
        wr_busy = 1'b0;
        continue;
      end
      if (st_read0 || st_write0 || st_read1 || st_write1) req_count++;
      if (done0) done_count0++;
      if (done1) done_count1++;
      if (st_write0) begin
        log_addr0.push_back(base_addr0);
        log_addr1.push_back(base_addr1);
        log_data0.push_back(write_data0);
        log_data1.push_back(write_data1);
        log_wr1.push_back(st_write1);
        a1 = base_addr0 + 8'd1;
        mem[base_addr0] = write_data0[7:0];
        mem[a1]         = write_data0[15:8];
        wr_busy = 1'b1;
        wr_cnt  = $urandom_range(0, 3);
      end else if (wr_busy) begin
        if (!hold_wr) begin
          if (wr_cnt == 0) begin
            wrt_done     = 1'b1;
            wr_busy      = 1'b0;
            last_wrt_cyc = cyc;
          end else wr_cnt--;
        end
      end else if (rd_busy) begin
        if (rd_cnt == 0) begin
          a1         = rd_addr + 8'd1;
          read_data  = {mem[a1], mem[rd_addr]};
          flip_ready = 1'b1;
          rd_busy    = 1'b0;
        end else rd_cnt--;
      end else if (st_read0) begin
        rd_busy = 1'b1;
        rd_cnt  = $urandom_range(0, 3);
        rd_addr = base_addr0;
      end else if ($urandom_range(0, 7) == 0) begin
        read_data = 16'($urandom);
        if ($urandom_range(0, 1) == 0) flip_ready = 1'b1;
        else wrt_done = 1'b1;
      end
    end
  end

  initial begin
    #800000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctl0"}, 32'({st_read0, st_write0, busy0, done0}), 32'd0);
    checkOutput({tag, "_addr0"}, 32'(base_addr0), 32'd0);
    checkOutput({tag, "_wdata0"}, 32'(write_data0), 32'd0);
    checkOutput({tag, "_wcount0"}, 32'(word_count0), 32'd0);
    checkOutput({tag, "_ctl1"}, 32'({st_read1, st_write1, busy1, done1, word_count1}), 32'd0);
    checkOutput({tag, "_data1"}, 32'({base_addr1, write_data1}), 32'd0);
  endtask

  task automatic randomizeSeed();
    for (int i = 0; i < 256; i++) seed_mem[i] = 8'($urandom);
  endtask

  // Runs one pass from the current seed image and checks it against the model.
  task automatic applyStimulus(input logic [7:0] b, input logic [3:0] c,
                               input logic [3:0] r, input logic [7:0] s,
                               input bit disturb);
    int n, d0, d1, rq, start_cyc, done_at;
    bit seen;
    logic [7:0] a, a1;
    logic [15:0] w;
    int bad;
    n = int'(c) * int'(r);
    exp_addr.delete();
    exp_d0.delete();
    exp_d1.delete();
    for (int i = 0; i < 256; i++) model_mem[i] = seed_mem[i];
    for (int rr = 0; rr < int'(r); rr++) begin
      for (int cc = 0; cc < int'(c); cc++) begin
        a  = 8'(int'(b) + rr * int'(s) + cc * 2);
        a1 = a + 8'd1;
        w  = {model_mem[a1], model_mem[a]};
        exp_addr.push_back(a);
        exp_d0.push_back({<<{w}});
        exp_d1.push_back({w[7:0], w[15:8]});
        model_mem[a]  = exp_d0[exp_d0.size()-1][7:0];
        model_mem[a1] = exp_d0[exp_d0.size()-1][15:8];
      end
    end
    load_req++;
    repeat (2) @(negedge clk);
    pass_base = log_addr0.size();
    d0 = done_count0;
    d1 = done_count1;
    rq = req_count;
    checkOutput("idle_before_start", 32'({st_read0, busy0, st_read1, busy1}), 32'd0);
    rect_base  = b;
    rect_cols  = c;
    rect_rows  = r;
    row_stride = s;
    start      = 1'b1;
    start_cyc  = cyc;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", 32'({busy0, busy1}), 32'b11);
    checkOutput("st_read_cycle1", 32'({st_read0, st_read1}), (n > 0) ? 32'b11 : 32'b00);
    if (disturb) begin
      rect_base  = 8'($urandom);
      rect_cols  = 4'($urandom);
      rect_rows  = 4'($urandom);
      row_stride = 8'($urandom);
    end
    seen    = 1'b0;
    done_at = 0;
    for (int k = 0; k < 6000 && !seen; k++) begin
      @(negedge clk);
      if (done0) begin
        seen    = 1'b1;
        done_at = cyc;
        start   = disturb;
      end else begin
        start = disturb && busy0 && ($urandom_range(0, 3) == 0);
      end
    end
    checkOutput("done_seen", 32'(seen), 32'd1);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("no_restart", 32'({busy0, st_read0, busy1, st_read1}), 32'd0);
    checkOutput("done_pulses0", 32'(done_count0 - d0), 32'd1);
    checkOutput("done_pulses1", 32'(done_count1 - d1), 32'd1);
    checkOutput("word_count0", 32'(word_count0), 32'(n));
    checkOutput("word_count1", 32'(word_count1), 32'(n));
    checkOutput("write_count", 32'(log_addr0.size() - pass_base), 32'(n));
    if (n == 0) begin
      checkOutput("empty_no_requests", 32'(req_count - rq), 32'd0);
      checkOutput("empty_done_latency", 32'(done_at - start_cyc), 32'd2);
    end else begin
      checkOutput("last_done_latency", 32'(done_at - last_wrt_cyc), 32'd2);
    end
    for (int i = 0; i < n && pass_base + i < log_addr0.size(); i++) begin
      checkOutput($sformatf("addr0_w%0d", i), 32'(log_addr0[pass_base+i]), 32'(exp_addr[i]));
      checkOutput($sformatf("addr1_w%0d", i), 32'(log_addr1[pass_base+i]), 32'(exp_addr[i]));
      checkOutput($sformatf("wdata0_w%0d", i), 32'(log_data0[pass_base+i]), 32'(exp_d0[i]));
      checkOutput($sformatf("wdata1_w%0d", i), 32'(log_data1[pass_base+i]), 32'(exp_d1[i]));
      checkOutput($sformatf("st_write1_w%0d", i), 32'(log_wr1[pass_base+i]), 32'd1);
    end
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== model_mem[i]) bad++;
    checkOutput("mem_image", 32'(bad), 32'd0);
  endtask

  initial begin
    logic [7:0] seq4 [4];
    reset      = 1'b1;
    start      = 1'b0;
    rect_base  = '0;
    rect_cols  = '0;
    rect_rows  = '0;
    row_stride = '0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] 1x1 word 0x1234");
    randomizeSeed();
    seed_mem[8'h20] = 8'h34;
    seed_mem[8'h21] = 8'h12;
    applyStimulus(8'h20, 4'd1, 4'd1, 8'h00, 1'b0);
    checkOutput("bitrev_1234", 32'(log_data0[pass_base]), 32'h2C48);
    checkOutput("byteswap_1234", 32'(log_data1[pass_base]), 32'h3412);

    $display("[TB] 2x2 rectangle stride 8");
    randomizeSeed();
    applyStimulus(8'h10, 4'd2, 4'd2, 8'h08, 1'b0);
    seq4 = '{8'h10, 8'h12, 8'h18, 8'h1A};
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("rect2x2_addr%0d", i), 32'(log_addr0[pass_base+i]), 32'(seq4[i]));

    $display("[TB] address wrap at 0xFE");
    randomizeSeed();
    applyStimulus(8'hFE, 4'd2, 4'd1, 8'h20, 1'b0);
    checkOutput("wrap_addr0", 32'(log_addr0[pass_base]), 32'h00FE);
    checkOutput("wrap_addr1", 32'(log_addr0[pass_base+1]), 32'h0000);
    checkOutput("wrap_count", 32'(word_count0), 32'd2);

    $display("[TB] empty pass");
    applyStimulus(8'h30, 4'd0, 4'd3, 8'h10, 1'b1);

    $display("[TB] randomized passes");
    for (int t = 0; t < 8; t++) begin
      randomizeSeed();
      applyStimulus(8'($urandom), 4'($urandom_range(1, 4)), 4'($urandom_range(1, 4)),
                    8'($urandom), 1'b1);
    end
    randomizeSeed();
    applyStimulus(8'($urandom), 4'd3, 4'd15, 8'($urandom), 1'b1);

    $display("[TB] reset during write wait");
    randomizeSeed();
    load_req++;
    repeat (2) @(negedge clk);
    rect_base  = 8'h40;
    rect_cols  = 4'd2;
    rect_rows  = 4'd2;
    row_stride = 8'h10;
    hold_wr    = 1'b1;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 200 && !wr_busy; k++) @(negedge clk);
    @(negedge clk);
    checkOutput("wwait_reached", 32'({wr_busy, busy0, st_read0, st_write0}), 32'b1100);
    #1 reset = 1'b1;
    #1 checkAllZero("async_reset");
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    hold_wr = 1'b0;
    @(negedge clk);
    randomizeSeed();
    applyStimulus(8'h40, 4'd2, 4'd2, 8'h10, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
